// File: rtl/fnn_pkg.sv
// Shared constants, FSM state type and output saturation helper for the
// fully-connected network neuron compute stages.
package fnn_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int FRAC_BITS  = 12;

    typedef enum logic [1:0] {ACC, DRAIN, FINAL, OUT} neuron_state_t;

    // ReLU followed by clamping to the largest positive data-width value.
    function automatic logic [DATA_WIDTH-1:0] relu_sat(input logic signed [2*DATA_WIDTH-1:0] s);
        logic signed [2*DATA_WIDTH-1:0] max_pos;
        max_pos = {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
        if (s < 0)
            return '0;
        else if (s > max_pos)
            return {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else
            return s[DATA_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/mac_unit.sv
// Fixed-point multiply-accumulate: acc += (x_d * w) >>> fracBits when en is high.
// clr empties the accumulator between frames.
module mac_unit
    import fnn_pkg::*;
#(
    parameter int dataWidth = DATA_WIDTH,
    parameter int fracBits  = FRAC_BITS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          en,
    input  logic signed [dataWidth-1:0]   x_d,
    input  logic signed [dataWidth-1:0]   w,
    output logic signed [2*dataWidth-1:0] acc
);

    logic signed [2*dataWidth-1:0] prod;

    // Both operands are signed, so they are sign-extended to the full product width.
    assign prod = x_d * w;

    always_ff @(posedge clk) begin
        if (rst || clr)
            acc <= '0;
        else if (en)
            acc <= acc + (prod >>> fracBits);
    end

endmodule

// File: rtl/neuron_mac_2_0.sv
// Layer-2 neuron 0: streams activations in, fetches matching weights,
// accumulates, adds bias, applies saturating ReLU and hands out one result per frame.
module neuron_mac_2_0
    import fnn_pkg::*;
#(
    parameter int                          numWeight    = 30,
    parameter int                          addressWidth = $clog2(numWeight),
    parameter int                          dataWidth    = DATA_WIDTH,
    parameter int                          fracBits     = FRAC_BITS,
    parameter logic signed [dataWidth-1:0] biasValue    = 16'sd0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        x_valid,
    output logic                        x_ready,
    input  logic [dataWidth-1:0]        x_in,
    output logic                        w_ren,
    output logic [addressWidth-1:0]     w_radd,
    input  logic [dataWidth-1:0]        w_rdata,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [dataWidth-1:0]        out_data
);

    localparam logic [addressWidth-1:0] LAST_IDX = addressWidth'(numWeight - 1);

    neuron_state_t                 state, next_state;
    logic [addressWidth-1:0]       cnt;
    logic signed [dataWidth-1:0]   x_d;
    logic                          mac_en;
    logic                          accept;
    logic                          acc_clr;
    logic signed [2*dataWidth-1:0] acc;
    logic signed [2*dataWidth-1:0] sum;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        next_state = state;
        x_ready    = 1'b0;
        acc_clr    = 1'b0;
        case (state)
            ACC: begin
                x_ready = 1'b1;
                if (x_valid && cnt == LAST_IDX)
                    next_state = DRAIN;
            end
            DRAIN: next_state = FINAL;
            FINAL: next_state = OUT;
            OUT: begin
                if (out_ready) begin
                    next_state = ACC;
                    acc_clr    = 1'b1;
                end
            end
            default: next_state = ACC;
        endcase
    end

    assign accept = x_valid && x_ready;
    assign w_ren  = accept;
    assign w_radd = cnt;
    assign sum    = acc + {{dataWidth{biasValue[dataWidth-1]}}, biasValue};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACC;
            cnt       <= '0;
            x_d       <= '0;
            mac_en    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state  <= next_state;
            mac_en <= accept;
            if (accept) begin
                x_d <= x_in;
                cnt <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
            end
            // The weight for x_d arrives one cycle after the read, alongside mac_en.
            if (state == FINAL) begin
                out_data  <= relu_sat(sum);
                out_valid <= 1'b1;
            end else if (state == OUT && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    mac_unit #(
        .dataWidth (dataWidth),
        .fracBits  (fracBits)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (acc_clr),
        .en  (mac_en),
        .x_d (x_d),
        .w   (w_rdata),
        .acc (acc)
    );

endmodule

// File: tb/tb_neuron_mac_2_0.sv
// Bench for neuron_mac_2_0: two instances (bias 0 and bias 1.0) share stimulus;
// a frame-level model predicts handshakes, addresses and results every cycle.
module tb_neuron_mac_2_0;

    localparam int NW   = 30;
    localparam int BIAS = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        x_valid;
    logic [15:0] x_in;
    logic        out_ready;

    logic        x_ready0, w_ren0, out_valid0;
    logic [4:0]  w_radd0;
    logic [15:0] w_rdata0, out_data0;
    logic        x_ready1, w_ren1, out_valid1;
    logic [4:0]  w_radd1;
    logic [15:0] w_rdata1, out_data1;

    int wmem [NW];
    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    logic [4:0] addr_q[$];

    // Frame-level model state
    int     m_idx  = 0;
    longint m_sum  = 0;
    bit     m_busy = 0;
    int     m_cd   = 0;
    bit     m_ov   = 0;
    longint m_exp0 = 0;
    longint m_exp1 = 0;

    always #5 clk = ~clk;

    neuron_mac_2_0 dut0 (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x_ready(x_ready0), .x_in(x_in),
        .w_ren(w_ren0), .w_radd(w_radd0), .w_rdata(w_rdata0),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0)
    );

    neuron_mac_2_0 #(.biasValue(16'sd4096)) dut1 (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x_ready(x_ready1), .x_in(x_in),
        .w_ren(w_ren1), .w_radd(w_radd1), .w_rdata(w_rdata1),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1)
    );

    // Weight memories with one cycle of read latency
    always @(posedge clk) begin
        if (w_ren0) w_rdata0 <= 16'(wmem[w_radd0]);
        if (w_ren1) w_rdata1 <= 16'(wmem[w_radd1]);
        if (w_ren0) addr_q.push_back(w_radd0);
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint floor_div(input longint p);
        longint q;
        q = p / 4096;
        if ((p % 4096) != 0 && p < 0) q = q - 1;
        return q;
    endfunction

    function automatic longint relu_model(input longint s);
        if (s < 0) return 0;
        if (s > 32767) return 32767;
        return s;
    endfunction

    // Model: accumulate accepted products; result appears on the third cycle after the last accept.
    always @(posedge clk) begin
        if (rst) begin
            m_idx = 0; m_sum = 0; m_busy = 0; m_cd = 0; m_ov = 0;
        end else if (m_ov) begin
            if (out_ready) begin
                m_ov = 0; m_busy = 0; m_idx = 0; m_sum = 0;
            end
        end else if (m_cd > 0) begin
            m_cd = m_cd - 1;
            if (m_cd == 0) begin
                m_ov   = 1;
                m_exp0 = relu_model(m_sum);
                m_exp1 = relu_model(m_sum + BIAS);
            end
        end else if (!m_busy && x_valid) begin
            m_sum = m_sum + floor_div(longint'($signed(x_in)) * longint'(wmem[m_idx]));
            m_idx = m_idx + 1;
            if (m_idx == NW) begin
                m_busy = 1;
                m_cd   = 2;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            check("x_ready0", x_ready0, !m_busy);
            check("x_ready1", x_ready1, !m_busy);
            check("w_ren0", w_ren0, x_valid && !m_busy);
            check("w_ren1", w_ren1, x_valid && !m_busy);
            if (w_ren0) check("w_radd0", w_radd0, m_idx);
            check("out_valid0", out_valid0, m_ov);
            check("out_valid1", out_valid1, m_ov);
            if (m_ov) begin
                check("out_data0", out_data0, m_exp0);
                check("out_data1", out_data1, m_exp1);
            end
        end
    end

    task automatic frame(input int xv, input int wv, input bit gaps, input int hold,
                         input bit xv_during_out, output int res0, output int res1);
        int n = 0;
        int cyc = 0;
        int last = 0;
        bit seen = 0;
        for (int i = 0; i < NW; i++) wmem[i] = wv;
        addr_q.delete();
        out_ready = (hold == 0);
        while (n < NW && cyc < 200) begin
            x_valid = gaps ? (cyc % 2 == 0) : 1'b1;
            x_in    = 16'(xv);
            @(negedge clk);
            if (x_valid && x_ready0) begin
                n++;
                last = cyc;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("accept_count", n, NW);
        x_valid = xv_during_out;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (out_valid0) seen = 1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        check("out_valid_seen", seen, 1);
        check("latency", cyc - last, 3);
        res0 = int'(out_data0);
        res1 = int'(out_data1);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("hold_valid", out_valid0, 1);
            check("hold_data", out_data0, res0);
            check("hold_x_ready", x_ready0, 0);
            check("hold_w_ren", w_ren0, 0);
        end
        if (hold > 0) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        x_valid = 1'b0;
        @(negedge clk);
        check("released_valid", out_valid0, 0);
        check("released_x_ready", x_ready0, 1);
        check("addr_count", addr_q.size(), NW);
        for (int i = 0; i < addr_q.size() && i < NW; i++) check("addr_seq", addr_q[i], i);
        @(posedge clk); #1;
    endtask

    initial begin
        int r0, r1, n, guard;
        rst = 1'b1; x_valid = 1'b0; x_in = '0; out_ready = 1'b1;
        for (int i = 0; i < NW; i++) wmem[i] = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);
        check("rst_out_valid", out_valid0, 0);
        check("rst_out_data", out_data0, 0);
        check("rst_x_ready", x_ready0, 1);
        check("rst_out_data1", out_data1, 0);
        @(posedge clk); #1;

        // 1 basic
        frame(256, 2048, 0, 0, 0, r0, r1);
        check("t1_data", r0, 3840);
        check("t1_data_bias", r1, 7936);
        // 2 relu, with and without bias
        frame(256, -2048, 0, 0, 0, r0, r1);
        check("t2_data", r0, 0);
        check("t2_data_bias", r1, 256);
        // 3 saturation
        frame(4096, 4096, 0, 0, 0, r0, r1);
        check("t3_data", r0, 32767);
        check("t3_data_bias", r1, 32767);
        // 4 gaps
        frame(256, 2048, 1, 0, 0, r0, r1);
        check("t4_data", r0, 3840);
        // 5 backpressure with x_valid held during the result, then a clean frame
        frame(256, 2048, 0, 5, 1, r0, r1);
        check("t5_data", r0, 3840);
        frame(256, -1024, 0, 0, 0, r0, r1);
        check("t5_next_data_bias", r1, 2176);

        // 6 reset after 10 accepts, then a full frame
        for (int i = 0; i < NW; i++) wmem[i] = 2048;
        n = 0; guard = 0;
        x_in = 16'd256;
        while (n < 10 && guard < 100) begin
            x_valid = 1'b1;
            @(negedge clk);
            if (x_valid && x_ready0) n++;
            @(posedge clk); #1;
            guard++;
        end
        check("t6_partial_accepts", n, 10);
        x_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        frame(256, 2048, 0, 0, 0, r0, r1);
        check("t6_data", r0, 3840);
        check("t6_first_addr", (addr_q.size() > 0) ? int'(addr_q[0]) : -1, 0);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
